// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scanner with slot prescaler, anode ghost guard,
// frame-synchronous double buffering, leading-zero blanking and whole-display blink.
module seg_scan_ctrl #(
   parameter int DIGITS       = 4,
   parameter int PRESCALE     = 50000,
   parameter int GUARD        = 2,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_mask,
   input  logic                  load,
   input  logic                  lzb_en,
   input  logic                  blink_en,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     an,
   output logic                  pending,
   output logic                  frame_tick
);

   localparam int SLOT_W = $clog2(PRESCALE);
   localparam int DIG_W  = $clog2(DIGITS);
   localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(PRESCALE - 1);
   localparam logic [SLOT_W-1:0] SLOT_GUARD = SLOT_W'(GUARD);
   localparam logic [DIG_W-1:0]  DIG_LAST   = DIG_W'(DIGITS - 1);
   localparam logic [FRM_W-1:0]  FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);

   // Active-low abcdefg encoding of a hex nibble
   function automatic logic [6:0] seg7(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         default: s = 7'b0111000;
      endcase
      return s;
   endfunction

   logic [SLOT_W-1:0]   slot_q, slot_d;
   logic [DIG_W-1:0]    dig_q, dig_d;
   logic [FRM_W-1:0]    fcnt_q, fcnt_d;
   logic                phase_q, phase_d;
   logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
   logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
   logic                pend_q, pend_d;
   logic [4*DIGITS-1:0] act_val_q, act_val_d;
   logic [DIGITS-1:0]   act_dp_q, act_dp_d;
   logic                lzb_q, lzb_d;
   logic [6:0]          seg_q, seg_d;
   logic                dp_q, dp_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic                tick_q, tick_d;

   logic                slot_wrap, dig_wrap, boundary;
   logic [3:0]          cur_nib;
   logic [DIGITS-1:0]   blank_vec;
   logic                zero_run;
   logic                in_guard;

   assign slot_wrap = (slot_q == SLOT_LAST);
   assign dig_wrap  = (dig_q == DIG_LAST);
   assign boundary  = slot_wrap && dig_wrap;
   assign cur_nib   = act_val_q[{dig_q, 2'b00} +: 4];
   assign in_guard  = (slot_q < SLOT_GUARD);

   // blank_vec[k] is set when nibble k and every nibble above it are zero
   always_comb begin
      zero_run  = 1'b1;
      blank_vec = '0;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         zero_run     = zero_run & (act_val_q[4*k +: 4] == 4'h0);
         blank_vec[k] = zero_run;
      end
   end

   always_comb begin
      slot_d     = slot_wrap ? '0 : slot_q + 1'b1;
      dig_d      = dig_q;
      fcnt_d     = fcnt_q;
      phase_d    = phase_q;
      pend_val_d = pend_val_q;
      pend_dp_d  = pend_dp_q;
      pend_d     = pend_q;
      act_val_d  = act_val_q;
      act_dp_d   = act_dp_q;
      lzb_d      = lzb_q;

      if (slot_wrap) begin
         dig_d = dig_wrap ? '0 : dig_q + 1'b1;
      end

      if (boundary) begin
         if (fcnt_q == FRM_LAST) begin
            fcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end

      // A load in the boundary cycle wins over the commit and defers it a frame
      if (load) begin
         pend_val_d = value;
         pend_dp_d  = dp_mask;
         pend_d     = 1'b1;
      end else if (boundary && pend_q) begin
         act_val_d = pend_val_q;
         act_dp_d  = pend_dp_q;
         lzb_d     = lzb_en;
         pend_d    = 1'b0;
      end

      seg_d  = (lzb_q && blank_vec[dig_q]) ? 7'b1111111 : seg7(cur_nib);
      dp_d   = ~act_dp_q[dig_q];
      an_d   = (in_guard || (blink_en && phase_q)) ? '1 : ~(DIGITS'(1) << dig_q);
      tick_d = boundary;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q     <= '0;
         dig_q      <= '0;
         fcnt_q     <= '0;
         phase_q    <= 1'b0;
         pend_val_q <= '0;
         pend_dp_q  <= '0;
         pend_q     <= 1'b0;
         act_val_q  <= '0;
         act_dp_q   <= '0;
         lzb_q      <= 1'b0;
         seg_q      <= 7'b1111111;
         dp_q       <= 1'b1;
         an_q       <= '1;
         tick_q     <= 1'b0;
      end else begin
         slot_q     <= slot_d;
         dig_q      <= dig_d;
         fcnt_q     <= fcnt_d;
         phase_q    <= phase_d;
         pend_val_q <= pend_val_d;
         pend_dp_q  <= pend_dp_d;
         pend_q     <= pend_d;
         act_val_q  <= act_val_d;
         act_dp_q   <= act_dp_d;
         lzb_q      <= lzb_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         an_q       <= an_d;
         tick_q     <= tick_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;
   assign pending    = pend_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random traffic, each cycle
// compared against a cycle-count-based behavioural model of the display.
module tb_seg_scan_ctrl;

   localparam int D     = 4;
   localparam int P     = 4;
   localparam int G     = 1;
   localparam int BF    = 2;
   localparam int FRAME = P * D;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [15:0]   value;
   logic [3:0]    dp_mask;
   logic          load, lzb_en, blink_en;
   logic [6:0]    seg;
   logic          dp;
   logic [3:0]    an;
   logic          pending, frame_tick;

   seg_scan_ctrl #(.DIGITS(D), .PRESCALE(P), .GUARD(G), .BLINK_FRAMES(BF)) dut (
      .clk(clk), .rst_n(rst_n), .value(value), .dp_mask(dp_mask), .load(load),
      .lzb_en(lzb_en), .blink_en(blink_en), .seg(seg), .dp(dp), .an(an),
      .pending(pending), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   logic [6:0] SEG_TBL [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   int n_checks = 0;
   int n_pass   = 0;

   // Model: cycles since reset release, pending and active buffers
   int          c;
   logic [15:0] m_pval, m_aval;
   logic [3:0]  m_pdp, m_adp;
   logic        m_pend, m_lzb;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v)
         $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, c, obs, exp_v);
      else
         n_pass++;
   endtask

   task automatic model_reset();
      c      = 0;
      m_pval = '0;
      m_aval = '0;
      m_pdp  = '0;
      m_adp  = '0;
      m_pend = 1'b0;
      m_lzb  = 1'b0;
   endtask

   task automatic check_reset_outputs();
      chk("rst_an",   32'(an),         32'hF);
      chk("rst_seg",  32'(seg),        32'h7F);
      chk("rst_dp",   32'(dp),         32'h1);
      chk("rst_pend", 32'(pending),    32'h0);
      chk("rst_tick", 32'(frame_tick), 32'h0);
   endtask

   // One clock: predict from current inputs and model state, clock, compare
   task automatic step();
      int         slot, dig, hi;
      logic       bnd, ph, blank;
      logic [3:0] e_an, nib;
      logic [6:0] e_seg;
      logic       e_dp;
      slot = c % P;
      dig  = (c / P) % D;
      bnd  = (slot == P - 1) && (dig == D - 1);
      ph   = (((c / FRAME) / BF) % 2) == 1;
      e_an = (slot < G || (blink_en && ph)) ? 4'hF : ~(4'b0001 << dig);
      hi = 0;
      for (int k = 0; k < D; k++)
         if (m_aval[4*k +: 4] != 4'h0) hi = k;
      blank = m_lzb && (dig > hi);
      nib   = m_aval[4*dig +: 4];
      e_seg = blank ? 7'h7F : SEG_TBL[nib];
      e_dp  = ~m_adp[dig];
      if (load) begin
         m_pval = value;
         m_pdp  = dp_mask;
         m_pend = 1'b1;
      end else if (bnd && m_pend) begin
         m_aval = m_pval;
         m_adp  = m_pdp;
         m_lzb  = lzb_en;
         m_pend = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("an",      32'(an),         32'(e_an));
      chk("seg",     32'(seg),        32'(e_seg));
      chk("dp",      32'(dp),         32'(e_dp));
      chk("tick",    32'(frame_tick), 32'(bnd));
      chk("pending", 32'(pending),    32'(m_pend));
      c++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_slot(input int target);
      while (c % FRAME != target) step();
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] m);
      value   = v;
      dp_mask = m;
      load    = 1'b1;
      step();
      load    = 1'b0;
   endtask

   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n    = 1'b0;
      value    = '0;
      dp_mask  = '0;
      load     = 1'b0;
      lzb_en   = 1'b0;
      blink_en = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;

      // Idle scan with a load at cycle 5
      run(5);
      do_load(16'h12AF, 4'b0000);
      run(34);
      run(16);

      // Leading-zero blanking with a decimal point on a blanked digit
      lzb_en = 1'b1;
      wait_slot(3);
      do_load(16'h0030, 4'b0100);
      run(40);
      do_load(16'h0000, 4'b0001);
      run(36);
      lzb_en = 1'b0;

      // Last load wins, then a load landing on the boundary cycle
      wait_slot(2);
      do_load(16'h1111, 4'b0000);
      run(3);
      do_load(16'h2222, 4'b1000);
      run(24);
      wait_slot(15);
      do_load(16'h3A5C, 4'b0011);
      run(40);

      // Blink for several half-periods, then drop it mid-frame
      blink_en = 1'b1;
      run(5 * FRAME + 7);
      blink_en = 1'b0;
      run(20);

      // Asynchronous reset mid-slot while a load is pending
      wait_slot(5);
      do_load(16'h4321, 4'b1010);
      run(1);
      async_reset();
      run(40);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         logic [15:0] msk;
         case ($urandom_range(0, 4))
            0: msk = 16'hFFFF;
            1: msk = 16'h0FFF;
            2: msk = 16'h00FF;
            3: msk = 16'h000F;
            default: msk = 16'h0000;
         endcase
         value   = 16'($urandom) & msk;
         dp_mask = 4'($urandom);
         lzb_en  = 1'($urandom);
         load    = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 59) == 0) blink_en = ~blink_en;
         step();
         load = 1'b0;
         if (i == 1700) async_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
